// File: rtl/cru_peri_rst_seq.sv
// Peripheral reset sequencer placed after the peripheral CRU.
// Order of operations: gate masked-in clocks, assert their resets, hold,
// ungate, then release the domains one at a time in index order with a
// programmable gap before each. One sequence with default timing runs
// automatically after the block's own reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | outputs static, waiting for a request (new or pending)
// GATE    | masked-in clocks stopped, GATE_CYC cycles
// ASSERT  | masked-in resets asserted, max(hold,1) cycles
// UNGATE  | all clocks running again, GATE_CYC cycles
// RELEASE | walk masked-in domains low to high, max(dly[i],1) gap each
// DONE    | one-cycle completion pulse

module cru_peri_rst_seq #(
    parameter int NUM_DOM  = 4,
    parameter int CNT_W    = 8,
    parameter int GATE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [NUM_DOM-1:0]       cfg_mask_i,
    input  logic [CNT_W-1:0]         cfg_hold_i,
    input  logic [NUM_DOM*CNT_W-1:0] cfg_dly_i,
    output logic [NUM_DOM-1:0]       clk_en_o,
    output logic [NUM_DOM-1:0]       rst_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pend_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GATE    = 3'd1,
        ASSERT  = 3'd2,
        UNGATE  = 3'd3,
        RELEASE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]         GATE_LD   = CNT_W'(GATE_CYC - 1);
    localparam logic [NUM_DOM-1:0]       DOM_ONE   = NUM_DOM'(1);
    localparam logic [NUM_DOM*CNT_W-1:0] DLY_RESET = {NUM_DOM{CNT_W'(1)}};

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [NUM_DOM-1:0]         r_mask;
    logic [CNT_W-1:0]           r_hold;
    logic [NUM_DOM*CNT_W-1:0]   r_dly;
    logic [NUM_DOM-1:0]         r_rem;
    logic [NUM_DOM-1:0]         r_clk_en;
    logic [NUM_DOM-1:0]         r_rst;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_pend;

    logic [NUM_DOM-1:0]         w_first_bit;
    logic [NUM_DOM-1:0]         w_cur_bit;
    logic [NUM_DOM-1:0]         w_rem_nxt;
    logic [NUM_DOM-1:0]         w_nxt_bit;
    logic [CNT_W-1:0]           w_first_ld;
    logic [CNT_W-1:0]           w_nxt_ld;

    // A programmed count of 0 behaves like 1; counters run N-1 down to 0.
    function automatic logic [CNT_W-1:0] ld1(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - 1'b1;
    endfunction

    // Counter load for the domain selected by a one-hot (or empty) vector.
    function automatic logic [CNT_W-1:0] dly_sel(
        input logic [NUM_DOM-1:0]       sel,
        input logic [NUM_DOM*CNT_W-1:0] dly
    );
        logic [CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (sel[i]) v = v | ld1(dly[i*CNT_W +: CNT_W]);
        end
        return v;
    endfunction

    // Lowest remaining domain is the one being released; masked-out
    // domains are never in r_rem so they cost no cycles.
    always_comb begin
        w_first_bit = r_mask & (~r_mask + DOM_ONE);
        w_cur_bit   = r_rem & (~r_rem + DOM_ONE);
        w_rem_nxt   = r_rem & ~w_cur_bit;
        w_nxt_bit   = w_rem_nxt & (~w_rem_nxt + DOM_ONE);
        w_first_ld  = dly_sel(w_first_bit, r_dly);
        w_nxt_ld    = dly_sel(w_nxt_bit, r_dly);
    end

    // Sequencer FSM with registered outputs and one-deep request queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ASSERT;
            r_cnt    <= '0;
            r_mask   <= '1;
            r_hold   <= CNT_W'(1);
            r_dly    <= DLY_RESET;
            r_rem    <= '0;
            r_clk_en <= '1;
            r_rst    <= '1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (req_i && (r_state != IDLE)) r_pend <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (req_i || r_pend) begin
                        r_state  <= GATE;
                        r_pend   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_mask   <= cfg_mask_i;
                        r_hold   <= cfg_hold_i;
                        r_dly    <= cfg_dly_i;
                        r_clk_en <= r_clk_en & ~cfg_mask_i;
                        r_cnt    <= GATE_LD;
                    end
                end
                GATE: begin
                    if (r_cnt == '0) begin
                        r_state <= ASSERT;
                        r_rst   <= r_rst | r_mask;
                        r_cnt   <= ld1(r_hold);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ASSERT: begin
                    if (r_cnt == '0) begin
                        r_state  <= UNGATE;
                        r_clk_en <= '1;
                        r_cnt    <= GATE_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                UNGATE: begin
                    if (r_cnt == '0) begin
                        r_state <= RELEASE;
                        r_rem   <= r_mask;
                        r_cnt   <= w_first_ld;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (r_rem == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_rst <= r_rst & ~w_cur_bit;
                        r_rem <= w_rem_nxt;
                        r_cnt <= w_nxt_ld;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_en_o = r_clk_en;
    assign rst_o    = r_rst;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign pend_o   = r_pend;

endmodule
